// File: rtl/timer_scheduler.sv
// Two-requester scheduler that shares one Timer and its interval lookup, with a per-job watchdog.
// Optional round-robin arbitration when TIMER_SCHED_RR_EN is defined; fixed priority otherwise.
module timer_scheduler #(
   parameter int unsigned PARAM_LAT = 1,
   parameter int unsigned MAX_SEC   = 15,
   parameter int unsigned CNT_W     = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic [1:0] int0,
   input  logic       req1,
   input  logic [1:0] int1,
   input  logic       expired,
   input  logic       one_hz_enable,
   output logic [1:0] interval,
   output logic       start_timer,
   output logic       grant0,
   output logic       grant1,
   output logic       done0,
   output logic       done1,
   output logic       timeout,
   output logic       busy,
   output logic [2:0] estado
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSelect = 3'd1,
      StStart  = 3'd2,
      StRun    = 3'd3,
      StDone   = 3'd4
   } state_e;

   localparam logic [2:0]     LAT_END = 3'(PARAM_LAT);
   localparam logic [CNT_W:0] SEC_END = (CNT_W + 1)'(MAX_SEC);

   state_e           state_q;
   logic             owner_q;
   logic [2:0]       lat_q;
   logic [CNT_W-1:0] wd_q;
   logic             first_q;
   logic [CNT_W:0]   wd_inc;
   logic             owner_req;
   logic             abort;
   logic             pick;

   assign estado    = state_q;
   assign owner_req = owner_q ? req1 : req0;
   assign abort     = (state_q == StSelect || state_q == StStart || state_q == StRun) && !owner_req;
   assign wd_inc    = {1'b0, wd_q} + {{CNT_W{1'b0}}, 1'b1};

`ifdef TIMER_SCHED_RR_EN
   logic last_owner_q;

   // On a tie the requester that did not finish the previous job wins.
   assign pick = (req0 && req1) ? !last_owner_q : !req0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_owner_q <= 1'b1;
      end else if (state_q == StDone) begin
         last_owner_q <= owner_q;
      end
   end
`else
   assign pick = !req0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         lat_q       <= '0;
         wd_q        <= '0;
         first_q     <= 1'b0;
         interval    <= '0;
         start_timer <= 1'b0;
         grant0      <= 1'b0;
         grant1      <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         timeout     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         start_timer <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         timeout     <= 1'b0;
         if (abort) begin
            // An issued start pulse is not recalled; the next job restarts the Timer.
            state_q <= StIdle;
            grant0  <= 1'b0;
            grant1  <= 1'b0;
            busy    <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (req0 || req1) begin
                     owner_q  <= pick;
                     interval <= pick ? int1 : int0;
                     grant0   <= !pick;
                     grant1   <= pick;
                     lat_q    <= '0;
                     busy     <= 1'b1;
                     state_q  <= StSelect;
                  end
               end
               StSelect: begin
                  if (lat_q == LAT_END) begin
                     start_timer <= 1'b1;
                     state_q     <= StStart;
                  end else begin
                     lat_q <= lat_q + 3'd1;
                  end
               end
               StStart: begin
                  wd_q    <= '0;
                  first_q <= 1'b1;
                  state_q <= StRun;
               end
               StRun: begin
                  first_q <= 1'b0;
                  // A stale expired flag in the first RUN cycle belongs to an earlier job.
                  if (!first_q && expired) begin
                     done0   <= !owner_q;
                     done1   <= owner_q;
                     state_q <= StDone;
                  end else if (one_hz_enable) begin
                     if (wd_inc == SEC_END) begin
                        done0   <= !owner_q;
                        done1   <= owner_q;
                        timeout <= 1'b1;
                        state_q <= StDone;
                     end else begin
                        wd_q <= wd_inc[CNT_W-1:0];
                     end
                  end
               end
               StDone: begin
                  grant0  <= 1'b0;
                  grant1  <= 1'b0;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
